// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - polls a UART Lite over AXI4-lite and writes a length-prefixed image into instruction BRAM
// Optional UART_BOOT_LOADER_ACK_EN: after the last word, wait for TX space and send a single 0xAA acknowledge byte.
module uart_boot_loader #(
  parameter int unsigned MAX_WORDS = 16384,
  parameter logic [3:0]  RX_ADDR   = 4'h0,
  parameter logic [3:0]  TX_ADDR   = 4'h4,
  parameter logic [3:0]  STAT_ADDR = 4'h8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [3:0]  uart_axi_araddr,
  output logic        uart_axi_arvalid,
  input  logic        uart_axi_arready,
  input  logic [31:0] uart_axi_rdata,
  input  logic [1:0]  uart_axi_rresp,
  input  logic        uart_axi_rvalid,
  output logic        uart_axi_rready,
  output logic [3:0]  uart_axi_awaddr,
  output logic        uart_axi_awvalid,
  input  logic        uart_axi_awready,
  output logic [31:0] uart_axi_wdata,
  output logic [3:0]  uart_axi_wstrb,
  output logic        uart_axi_wvalid,
  input  logic        uart_axi_wready,
  input  logic [1:0]  uart_axi_bresp,
  input  logic        uart_axi_bvalid,
  output logic        uart_axi_bready,
  output logic [31:0] inst_addra,
  output logic [31:0] inst_dina,
  output logic [3:0]  inst_wea,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned WCW = $clog2(MAX_WORDS + 1);

  typedef enum logic [3:0] {
    IDLE, AR_STAT, R_STAT, AR_RX, R_RX, WRITE, FINISH, DONE_ST, ERR_ST,
    ACK_AR, ACK_R, ACK_W, ACK_B
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    sh_q, sh_d;
  logic [1:0]     bcnt_q, bcnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           hdr_q, hdr_d;
  logic [31:0]    word_next;

  // Only the low byte of RX data and two status bits carry meaning.
  logic unused_rdata;
  assign unused_rdata = ^uart_axi_rdata[31:8];

`ifdef UART_BOOT_LOADER_ACK_EN
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
`else
  assign uart_axi_awaddr  = '0;
  assign uart_axi_awvalid = 1'b0;
  assign uart_axi_wdata   = '0;
  assign uart_axi_wstrb   = '0;
  assign uart_axi_wvalid  = 1'b0;
  assign uart_axi_bready  = 1'b0;

  logic unused_ack;
  assign unused_ack = ^{uart_axi_awready, uart_axi_wready, uart_axi_bresp, uart_axi_bvalid};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sh_q    <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      hdr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      hdr_q   <= hdr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    sh_d             = sh_q;
    bcnt_d           = bcnt_q;
    wcnt_d           = wcnt_q;
    hdr_d            = hdr_q;
    uart_axi_araddr  = '0;
    uart_axi_arvalid = 1'b0;
    uart_axi_rready  = 1'b0;
    inst_addra       = '0;
    inst_dina        = '0;
    inst_wea         = '0;
    word_next        = {sh_q[23:0], uart_axi_rdata[7:0]};
`ifdef UART_BOOT_LOADER_ACK_EN
    uart_axi_awaddr  = '0;
    uart_axi_awvalid = 1'b0;
    uart_axi_wdata   = '0;
    uart_axi_wstrb   = '0;
    uart_axi_wvalid  = 1'b0;
    uart_axi_bready  = 1'b0;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = AR_STAT;
          hdr_d   = 1'b1;
        end
      end
      AR_STAT: begin
        uart_axi_araddr  = STAT_ADDR;
        uart_axi_arvalid = 1'b1;
        if (uart_axi_arready) state_d = R_STAT;
      end
      R_STAT: begin
        uart_axi_rready = 1'b1;
        if (uart_axi_rvalid) begin
          if (uart_axi_rresp != 2'b00)  state_d = ERR_ST;
          else if (uart_axi_rdata[0])   state_d = AR_RX;
          else                          state_d = AR_STAT;
        end
      end
      AR_RX: begin
        uart_axi_araddr  = RX_ADDR;
        uart_axi_arvalid = 1'b1;
        if (uart_axi_arready) state_d = R_RX;
      end
      R_RX: begin
        uart_axi_rready = 1'b1;
        if (uart_axi_rvalid) begin
          if (uart_axi_rresp != 2'b00) begin
            state_d = ERR_ST;
          end else begin
            sh_d    = word_next;
            bcnt_d  = bcnt_q + 2'd1;
            state_d = AR_STAT;
            // First completed word is the image length, not payload.
            if (bcnt_q == 2'd3) begin
              if (!hdr_q) begin
                state_d = WRITE;
              end else if (word_next > MAX_WORDS) begin
                state_d = ERR_ST;
              end else if (word_next == 32'd0) begin
                state_d = FINISH;
              end else begin
                wcnt_d = word_next[WCW-1:0];
                hdr_d  = 1'b0;
              end
            end
          end
        end
      end
      WRITE: begin
        inst_addra = addr_q;
        inst_dina  = sh_q;
        inst_wea   = 4'b1111;
        addr_d     = addr_q + 32'd4;
        wcnt_d     = wcnt_q - WCW'(1);
        state_d    = (wcnt_q == WCW'(1)) ? FINISH : AR_STAT;
      end
`ifdef UART_BOOT_LOADER_ACK_EN
      FINISH: state_d = ACK_AR;
      ACK_AR: begin
        uart_axi_araddr  = STAT_ADDR;
        uart_axi_arvalid = 1'b1;
        if (uart_axi_arready) state_d = ACK_R;
      end
      ACK_R: begin
        uart_axi_rready = 1'b1;
        if (uart_axi_rvalid) begin
          if (uart_axi_rresp != 2'b00) state_d = ERR_ST;
          else if (!uart_axi_rdata[3]) state_d = ACK_W;
          else                         state_d = ACK_AR;
        end
      end
      ACK_W: begin
        // Address and data channels may complete on different cycles.
        uart_axi_awaddr  = TX_ADDR;
        uart_axi_wdata   = 32'h0000_00AA;
        uart_axi_wstrb   = 4'b0001;
        uart_axi_awvalid = !aw_done_q;
        uart_axi_wvalid  = !w_done_q;
        aw_done_d        = aw_done_q | uart_axi_awready;
        w_done_d         = w_done_q | uart_axi_wready;
        if (aw_done_d && w_done_d) begin
          state_d   = ACK_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ACK_B: begin
        uart_axi_bready = 1'b1;
        if (uart_axi_bvalid) state_d = (uart_axi_bresp != 2'b00) ? ERR_ST : DONE_ST;
      end
`else
      FINISH: state_d = DONE_ST;
`endif
      DONE_ST: state_d = DONE_ST;
      ERR_ST:  state_d = ERR_ST;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE) && (state_q != DONE_ST) && (state_q != ERR_ST);
  assign done = (state_q == DONE_ST);
  assign err  = (state_q == ERR_ST);

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed self-checking bench for uart_boot_loader with a zero-wait UART Lite slave model
module tb_uart_boot_loader;

`ifdef UART_BOOT_LOADER_ACK_EN
  localparam bit ACK_ON = 1'b1;
`else
  localparam bit ACK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  uart_axi_araddr;
  logic        uart_axi_arvalid;
  logic        uart_axi_arready = 1'b1;
  logic [31:0] uart_axi_rdata = '0;
  logic [1:0]  uart_axi_rresp = '0;
  logic        uart_axi_rvalid = 1'b0;
  logic        uart_axi_rready;
  logic [3:0]  uart_axi_awaddr;
  logic        uart_axi_awvalid;
  logic        uart_axi_awready = 1'b1;
  logic [31:0] uart_axi_wdata;
  logic [3:0]  uart_axi_wstrb;
  logic        uart_axi_wvalid;
  logic        uart_axi_wready = 1'b1;
  logic [1:0]  uart_axi_bresp = '0;
  logic        uart_axi_bvalid = 1'b0;
  logic        uart_axi_bready;
  logic [31:0] inst_addra;
  logic [31:0] inst_dina;
  logic [3:0]  inst_wea;
  logic        busy, done, err;

  always #5 clk = ~clk;

  uart_boot_loader dut (
    .clk(clk), .rstn(rstn), .start(start),
    .uart_axi_araddr(uart_axi_araddr), .uart_axi_arvalid(uart_axi_arvalid), .uart_axi_arready(uart_axi_arready),
    .uart_axi_rdata(uart_axi_rdata), .uart_axi_rresp(uart_axi_rresp), .uart_axi_rvalid(uart_axi_rvalid),
    .uart_axi_rready(uart_axi_rready),
    .uart_axi_awaddr(uart_axi_awaddr), .uart_axi_awvalid(uart_axi_awvalid), .uart_axi_awready(uart_axi_awready),
    .uart_axi_wdata(uart_axi_wdata), .uart_axi_wstrb(uart_axi_wstrb), .uart_axi_wvalid(uart_axi_wvalid),
    .uart_axi_wready(uart_axi_wready),
    .uart_axi_bresp(uart_axi_bresp), .uart_axi_bvalid(uart_axi_bvalid), .uart_axi_bready(uart_axi_bready),
    .inst_addra(inst_addra), .inst_dina(inst_dina), .inst_wea(inst_wea),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // slave model state and observation logs
  logic [7:0]  rx_q[$];
  logic [3:0]  ar_log[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  last_ar = 4'hF;
  int stat_zeros = 0, zeros_left = 0, rx_reads = 0, err_at = 0;
  int bad_wea = 0, post_err_act = 0, busy_drop = 0;
  int tx_count = 0;
  logic [3:0]  tx_addr;
  logic [31:0] tx_data;
  logic [3:0]  tx_strb;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      uart_axi_rvalid = 1'b0;
      uart_axi_rdata  = '0;
      uart_axi_rresp  = 2'b00;
      uart_axi_bvalid = uart_axi_bready;
      if (uart_axi_rready) begin
        uart_axi_rvalid = 1'b1;
        if (last_ar == 4'h8) begin
          if (zeros_left > 0) zeros_left--;
          else uart_axi_rdata = 32'h1;
        end else begin
          rx_reads++;
          zeros_left = stat_zeros;
          if (rx_q.size() > 0) uart_axi_rdata = {24'h0, rx_q.pop_front()};
          if (rx_reads == err_at) uart_axi_rresp = 2'b10;
        end
      end
      if (uart_axi_arvalid) begin
        ar_log.push_back(uart_axi_araddr);
        last_ar = uart_axi_araddr;
      end
      if (inst_wea != 4'h0) begin
        wr_addr.push_back(inst_addra);
        wr_data.push_back(inst_dina);
        if (inst_wea != 4'hF) bad_wea++;
      end
      if (uart_axi_awvalid && uart_axi_wvalid) begin
        tx_count++;
        tx_addr = uart_axi_awaddr;
        tx_data = uart_axi_wdata;
        tx_strb = uart_axi_wstrb;
      end
      if (err && (uart_axi_arvalid || uart_axi_awvalid || uart_axi_wvalid || inst_wea != 4'h0)) post_err_act++;
    end
  end

  function automatic logic [127:0] out_vec();
    return {uart_axi_araddr, uart_axi_arvalid, uart_axi_rready, uart_axi_awaddr, uart_axi_awvalid,
            uart_axi_wdata, uart_axi_wstrb, uart_axi_wvalid, uart_axi_bready,
            inst_addra, inst_dina, inst_wea, busy, done, err};
  endfunction

  task automatic reset_dut(input string tag, input int zeros);
    rstn  = 1'b0;
    start = 1'b0;
    rx_q.delete(); ar_log.delete(); wr_addr.delete(); wr_data.delete();
    last_ar = 4'hF; rx_reads = 0; err_at = 0; bad_wea = 0; post_err_act = 0;
    busy_drop = 0; tx_count = 0;
    stat_zeros = zeros; zeros_left = zeros;
    step(); step();
    check_eq({tag, "_reset_outputs"}, out_vec(), '0);
    rstn = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w);
    rx_q.push_back(w[31:24]);
    rx_q.push_back(w[23:16]);
    rx_q.push_back(w[15:8]);
    rx_q.push_back(w[7:0]);
  endtask

  task automatic run_load(input string tag, output int cycles);
    start  = 1'b1;
    cycles = 0;
    while (!(done || err) && cycles < 3000) begin
      step();
      cycles++;
      if (!busy && !done && !err) busy_drop++;
    end
    check_eq({tag, "_timeout"}, !(done || err), 1'b0);
  endtask

  task automatic check_end(input string tag, input bit exp_done, input int exp_wr, input int exp_tx);
    check_eq({tag, "_done"}, done, exp_done);
    check_eq({tag, "_err"}, err, !exp_done);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_wr_count"}, wr_addr.size(), exp_wr);
    check_eq({tag, "_wea_value"}, bad_wea, 0);
    check_eq({tag, "_tx_count"}, tx_count, exp_tx);
    check_eq({tag, "_busy_drop"}, busy_drop, 0);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ga, gd;
    ga = 'x;
    gd = 'x;
    if (idx < wr_addr.size()) begin
      ga = wr_addr[idx];
      gd = wr_data[idx];
    end
    check_eq({tag, "_addr"}, ga, a);
    check_eq({tag, "_data"}, gd, d);
  endtask

  task automatic check_ar_log(input string tag, input int nbytes, input int zeros, input bit ack_tail);
    logic [3:0] exp_q[$];
    int mism;
    mism = 0;
    for (int b = 0; b < nbytes; b++) begin
      for (int z = 0; z <= zeros; z++) exp_q.push_back(4'h8);
      exp_q.push_back(4'h0);
    end
    if (ack_tail) exp_q.push_back(4'h8);
    check_eq({tag, "_ar_count"}, ar_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ar_log.size(); i++)
      if (ar_log[i] !== exp_q[i]) mism++;
    check_eq({tag, "_ar_order"}, mism, 0);
  endtask

  initial begin
    int cyc;
    step();

    // two-word image, status always ready
    reset_dut("t1", 0);
    push_word(32'h0000_0002); push_word(32'hDEAD_BEEF); push_word(32'h0123_4567);
    run_load("t1", cyc);
    check_eq("t1_latency", cyc, 52 + (ACK_ON ? 4 : 0));
    check_end("t1", 1'b1, 2, ACK_ON ? 1 : 0);
    check_wr("t1_w0", 0, 32'h0, 32'hDEAD_BEEF);
    check_wr("t1_w1", 1, 32'h4, 32'h0123_4567);
    check_ar_log("t1", 12, 0, ACK_ON);

    // five empty status polls before every byte
    reset_dut("t2", 5);
    push_word(32'h0000_0002); push_word(32'hDEAD_BEEF); push_word(32'h0123_4567);
    run_load("t2", cyc);
    check_end("t2", 1'b1, 2, ACK_ON ? 1 : 0);
    check_wr("t2_w0", 0, 32'h0, 32'hDEAD_BEEF);
    check_wr("t2_w1", 1, 32'h4, 32'h0123_4567);
    check_ar_log("t2", 12, 5, ACK_ON);

    // empty image
    reset_dut("t3", 0);
    push_word(32'h0000_0000);
    run_load("t3", cyc);
    check_end("t3", 1'b1, 0, ACK_ON ? 1 : 0);
`ifdef UART_BOOT_LOADER_ACK_EN
    check_eq("t3_tx_addr", tx_addr, 4'h4);
    check_eq("t3_tx_data", tx_data, 32'h0000_00AA);
    check_eq("t3_tx_strb", tx_strb, 4'b0001);
`endif

    // oversize header
    reset_dut("t4", 0);
    push_word(32'h0000_4001);
    run_load("t4", cyc);
    repeat (20) step();
    check_end("t4", 1'b0, 0, 0);
    check_eq("t4_post_err_activity", post_err_act, 0);
    check_ar_log("t4", 4, 0, 1'b0);

    // RX error on the third payload byte
    reset_dut("t5", 0);
    push_word(32'h0000_0002); push_word(32'hDEAD_BEEF); push_word(32'h0123_4567);
    err_at = 7;
    run_load("t5", cyc);
    repeat (20) step();
    check_end("t5", 1'b0, 0, 0);
    check_eq("t5_post_err_activity", post_err_act, 0);

    // RX error inside the second word keeps the first word
    reset_dut("t6", 0);
    push_word(32'h0000_0002); push_word(32'hDEAD_BEEF); push_word(32'h0123_4567);
    err_at = 11;
    run_load("t6", cyc);
    repeat (20) step();
    check_end("t6", 1'b0, 1, 0);
    check_wr("t6_w0", 0, 32'h0, 32'hDEAD_BEEF);
    check_eq("t6_post_err_activity", post_err_act, 0);

    // reset mid-word, then a fresh one-word image
    reset_dut("t7a", 0);
    push_word(32'h0000_0001); push_word(32'hAABB_CCDD);
    start = 1'b1;
    cyc = 0;
    while (rx_reads < 6 && cyc < 1000) begin
      step();
      cyc++;
    end
    check_eq("t7_reach_mid_word", rx_reads >= 6, 1'b1);
    reset_dut("t7b", 0);
    push_word(32'h0000_0001); push_word(32'h1122_3344);
    run_load("t7", cyc);
    check_end("t7", 1'b1, 1, ACK_ON ? 1 : 0);
    check_wr("t7_w0", 0, 32'h0, 32'h1122_3344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
